// File: rtl/blit_cmd_arbiter_if.sv
// rtl/blit_cmd_arbiter_if.sv - CPU/DL command ports and blit FIFO write side of the arbiter
interface blit_cmd_arbiter_if #(
  parameter int CMD_W  = 104,
  parameter int SLOT_W = 8
);
  logic [CMD_W-1:0]  cpu_cmd;
  logic              cpu_valid;
  logic              cpu_ready;
  logic [CMD_W-1:0]  dl_cmd;
  logic              dl_valid;
  logic              dl_ready;
  logic              hold;
  logic [SLOT_W-1:0] blit_slots_free;
  logic [CMD_W-1:0]  blit_cmd;
  logic              blit_start;
  logic              last_owner;
  logic [1:0]        inflight;

  modport master (
    output cpu_cmd, cpu_valid, dl_cmd, dl_valid, hold, blit_slots_free,
    input  cpu_ready, dl_ready, blit_cmd, blit_start, last_owner, inflight
  );

  modport slave (
    input  cpu_cmd, cpu_valid, dl_cmd, dl_valid, hold, blit_slots_free,
    output cpu_ready, dl_ready, blit_cmd, blit_start, last_owner, inflight
  );
endinterface

// File: rtl/blit_cmd_arbiter.sv
// rtl/blit_cmd_arbiter.sv - round-robin CPU/DL arbiter for the blit FIFO write port with lag-aware credits
// Optional DL slot reserve for the CPU: define BLIT_DL_RESERVE_EN.
module blit_cmd_arbiter #(
  parameter int CMD_W      = 104,
  parameter int SLOT_W     = 8,
  parameter int LAG        = 1,
  parameter int DL_RESERVE = 4
) (
  input  logic             clock,
  input  logic             reset,
  blit_cmd_arbiter_if.slave bus
);
`ifdef BLIT_DL_RESERVE_EN
  localparam logic signed [SLOT_W:0] DL_FLOOR = (SLOT_W+1)'(DL_RESERVE);
`else
  // Reserve disabled: the DL floor collapses to the plain non-empty test.
  localparam logic signed [SLOT_W:0] DL_FLOOR = (SLOT_W+1)'(DL_RESERVE * 0);
`endif

  logic [LAG:0]            hist;
  logic [1:0]              pend;
  logic signed [SLOT_W:0]  avail;
  logic                    cpu_ok;
  logic                    dl_ok;
  logic                    cpu_win;
  logic                    dl_win;
  logic                    grant_any;
  logic                    owner_q;
  logic                    start_q;
  logic [CMD_W-1:0]        cmd_q;

  always_comb begin
    pend = '0;
    for (int i = 0; i <= LAG; i++) begin
      pend = pend + 2'(hist[i]);
    end
  end

  // Grants still in flight are not yet visible in blit_slots_free, so deduct them here.
  assign avail  = $signed({1'b0, bus.blit_slots_free}) - $signed({{(SLOT_W-1){1'b0}}, pend});
  assign cpu_ok = reset && !bus.hold && !avail[SLOT_W] && (avail != '0);
  assign dl_ok  = reset && !bus.hold && (avail > DL_FLOOR);

  always_comb begin
    cpu_win = bus.cpu_valid && cpu_ok;
    dl_win  = bus.dl_valid && dl_ok;
    if (cpu_win && dl_win) begin
      cpu_win = owner_q;
      dl_win  = !owner_q;
    end
  end

  assign grant_any = cpu_win || dl_win;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist    <= '0;
      start_q <= 1'b0;
      cmd_q   <= '0;
      owner_q <= 1'b1;
    end else begin
      hist    <= {hist[LAG-1:0], grant_any};
      start_q <= grant_any;
      if (cpu_win) begin
        cmd_q   <= bus.cpu_cmd;
        owner_q <= 1'b0;
      end else if (dl_win) begin
        cmd_q   <= bus.dl_cmd;
        owner_q <= 1'b1;
      end
    end
  end

  assign bus.cpu_ready  = cpu_win;
  assign bus.dl_ready   = dl_win;
  assign bus.blit_start = start_q;
  assign bus.blit_cmd   = cmd_q;
  assign bus.last_owner = owner_q;
  assign bus.inflight   = pend;
endmodule
